instr_fetch: RTL and testbench

Fetch-side initiator for the instruction memory. Holds the program counter and drives the word address into `instr_mem`. It tracks the single request in flight, since read data arrives one cycle after the address. It presents fetched instructions to decode over a valid/ready handshake, with support for stall, redirect (branch/jump) and fetch enable.

---
 rtl/types_pkg.sv | 22 ++
 rtl/instr_fetch.sv | 102 ++++++++++
 tb/tb_instr_fetch.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/types_pkg.sv
`default_nettype none
// ============================================================================
// Module  : types_pkg
// Brief   : Shared memory/word types plus PC helpers for the fetch stage.
// Rev     : 1.0 - initial release
// ============================================================================
package types_pkg;

    localparam int MEM_SIZE = 512;
    localparam int ADDR_W   = $clog2(MEM_SIZE);

    typedef logic [ADDR_W-1:0] address_t;
    typedef logic [31:0]       word_t;
    typedef logic [31:0]       pc_t;

    // Word index of a byte PC; upper bits drop so addresses wrap modulo MEM_SIZE.
    function automatic address_t pc_to_addr(input pc_t i_pc);
        return i_pc[ADDR_W+1:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch
// Brief   : PC holder and instruction-memory initiator with a valid/ready
//           output to decode, supporting stall, redirect and fetch enable.
// Rev     : 1.0 - initial release
// ============================================================================
module instr_fetch
    import types_pkg::*;
#(
    parameter pc_t RESET_PC = 32'h0000_0000,
    parameter int  ADDR_W   = types_pkg::ADDR_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output address_t    imem_address,
    input  word_t       imem_instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output word_t       if_instr,
    output logic        misaligned,
    output logic [31:0] fetch_count
);

    localparam pc_t C_PC_STEP = 32'd4;

    pc_t         r_req_pc;
    logic        r_rsp_valid;
    pc_t         r_rsp_pc;
    logic [31:0] r_cnt;
    logic        r_misaligned;

    pc_t         w_tgt;
    logic        w_stall;
    logic        w_accept;
    pc_t         w_sel_pc;
    pc_t         w_nxt_req_pc;
    logic        w_nxt_rsp_valid;
    pc_t         w_nxt_rsp_pc;

    assign w_tgt    = {redirect_pc[31:2], 2'b00};
    assign w_stall  = r_rsp_valid && !if_ready;
    assign if_valid = r_rsp_valid && !redirect_valid && !rst;
    assign w_accept = if_valid && if_ready;

    // Next-PC mux: redirect beats stall beats normal issue.
    always_comb begin
        w_sel_pc        = r_req_pc;
        w_nxt_req_pc    = r_req_pc;
        w_nxt_rsp_valid = r_rsp_valid;
        w_nxt_rsp_pc    = r_rsp_pc;
        if (redirect_valid) begin
            w_sel_pc        = w_tgt;
            w_nxt_rsp_valid = 1'b1;
            w_nxt_rsp_pc    = w_tgt;
            w_nxt_req_pc    = w_tgt + C_PC_STEP;
        end else if (w_stall) begin
            // Re-read the held word so the memory output stays stable.
            w_sel_pc = r_rsp_pc;
        end else if (fetch_en) begin
            w_sel_pc        = r_req_pc;
            w_nxt_rsp_valid = 1'b1;
            w_nxt_rsp_pc    = r_req_pc;
            w_nxt_req_pc    = r_req_pc + C_PC_STEP;
        end else begin
            w_nxt_rsp_valid = 1'b0;
        end
        if (rst) begin
            w_sel_pc = RESET_PC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_pc     <= RESET_PC;
            r_rsp_valid  <= 1'b0;
            r_rsp_pc     <= RESET_PC;
            r_cnt        <= 32'd0;
            r_misaligned <= 1'b0;
        end else begin
            r_req_pc     <= w_nxt_req_pc;
            r_rsp_valid  <= w_nxt_rsp_valid;
            r_rsp_pc     <= w_nxt_rsp_pc;
            r_misaligned <= redirect_valid && (|redirect_pc[1:0]);
            if (w_accept) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    assign imem_address = w_sel_pc[ADDR_W+1:2];
    assign if_pc        = r_rsp_pc;
    assign if_instr     = imem_instruction;
    assign misaligned   = r_misaligned;
    assign fetch_count  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_fetch
// Brief   : Directed self-checking bench for instr_fetch with a 1-cycle memory.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;
    import types_pkg::*;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    address_t    imem_address;
    word_t       imem_instruction;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    word_t       if_instr;
    logic        misaligned;
    logic [31:0] fetch_count;

    int n_checks;
    int n_errors;

    word_t mem [MEM_SIZE];

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .ADDR_W   (9)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_en         (fetch_en),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .if_valid         (if_valid),
        .if_ready         (if_ready),
        .if_pc            (if_pc),
        .if_instr         (if_instr),
        .misaligned       (misaligned),
        .fetch_count      (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction memory.
    always @(posedge clk) imem_instruction <= mem[imem_address];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst            = 1'b1;
        fetch_en       = 1'b1;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick();
        tick();
    endtask

    task automatic test_reset;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        #1;
        n_checks++;
        if (if_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_if_valid got=%0b exp=0", if_valid);
        end
        n_checks++;
        if (imem_address !== 9'd0) begin
            n_errors++; $display("FAIL reset_addr got=%0d exp=0", imem_address);
        end
        n_checks++;
        if (fetch_count !== 32'd0) begin
            n_errors++; $display("FAIL reset_count got=%0d exp=0", fetch_count);
        end
        n_checks++;
        if (misaligned !== 1'b0 || if_pc !== 32'h0) begin
            n_errors++; $display("FAIL reset_state got mis=%0b pc=%h exp mis=0 pc=0", misaligned, if_pc);
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_sequential;
        word_t exp_i;
        do_reset();
        rst = 1'b0;
        #1;
        n_checks++;
        if (imem_address !== 9'd0 || if_valid !== 1'b0) begin
            n_errors++; $display("FAIL seq_first_issue got addr=%0d v=%0b exp addr=0 v=0", imem_address, if_valid);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_i = 32'hA000_0000 + k;
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'(4 * k) || if_instr !== exp_i) begin
                n_errors++;
                $display("FAIL seq_pc%0d got v=%0b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                         k, if_valid, if_pc, if_instr, 32'(4 * k), exp_i);
            end
        end
        n_checks++;
        if (fetch_count !== 32'd3) begin
            n_errors++; $display("FAIL seq_count got=%0d exp=3", fetch_count);
        end
    endtask

    task automatic test_stall;
        do_reset();
        rst = 1'b0;
        tick(); tick(); tick();
        if_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'd8 || if_instr !== 32'hA000_0002 ||
                imem_address !== 9'd2 || fetch_count !== 32'd2) begin
                n_errors++;
                $display("FAIL stall_hold%0d got v=%0b pc=%h instr=%h addr=%0d cnt=%0d exp v=1 pc=8 instr=a0000002 addr=2 cnt=2",
                         k, if_valid, if_pc, if_instr, imem_address, fetch_count);
            end
            tick();
        end
        if_ready = 1'b1;
        #1;
        n_checks++;
        if (if_pc !== 32'd8 || imem_address !== 9'd3) begin
            n_errors++; $display("FAIL stall_release got pc=%h addr=%0d exp pc=8 addr=3", if_pc, imem_address);
        end
        tick();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'd12 || if_instr !== 32'hA000_0003 || fetch_count !== 32'd3) begin
            n_errors++;
            $display("FAIL stall_resume got v=%0b pc=%h instr=%h cnt=%0d exp v=1 pc=c instr=a0000003 cnt=3",
                     if_valid, if_pc, if_instr, fetch_count);
        end
    endtask

    task automatic test_redirect;
        do_reset();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        #1;
        n_checks++;
        if (if_valid !== 1'b0 || imem_address !== 9'd16 || if_pc !== 32'd16) begin
            n_errors++; $display("FAIL redir_kill got v=%0b addr=%0d pc=%h exp v=0 addr=16 pc=10", if_valid, imem_address, if_pc);
        end
        tick();
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== 32'hA000_0010 || fetch_count !== 32'd4) begin
            n_errors++;
            $display("FAIL redir_target got v=%0b pc=%h instr=%h cnt=%0d exp v=1 pc=40 instr=a0000010 cnt=4",
                     if_valid, if_pc, if_instr, fetch_count);
        end
        tick();
        n_checks++;
        if (if_pc !== 32'h44 || fetch_count !== 32'd5 || misaligned !== 1'b0) begin
            n_errors++; $display("FAIL redir_next got pc=%h cnt=%0d mis=%0b exp pc=44 cnt=5 mis=0", if_pc, fetch_count, misaligned);
        end
    endtask

    task automatic test_misaligned;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0042;
        tick();
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (misaligned !== 1'b1 || if_pc !== 32'h40 || if_instr !== 32'hA000_0010) begin
            n_errors++; $display("FAIL misal_pulse got mis=%0b pc=%h instr=%h exp mis=1 pc=40 instr=a0000010", misaligned, if_pc, if_instr);
        end
        tick();
        n_checks++;
        if (misaligned !== 1'b0 || if_pc !== 32'h44) begin
            n_errors++; $display("FAIL misal_clear got mis=%0b pc=%h exp mis=0 pc=44", misaligned, if_pc);
        end
    endtask

    task automatic test_wrap;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_07FC;
        tick();
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (if_pc !== 32'h7FC || if_instr !== 32'hA000_01FF || imem_address !== 9'd0) begin
            n_errors++; $display("FAIL wrap_last got pc=%h instr=%h addr=%0d exp pc=7fc instr=a00001ff addr=0", if_pc, if_instr, imem_address);
        end
        tick();
        n_checks++;
        if (if_pc !== 32'h800 || if_instr !== 32'hA000_0000) begin
            n_errors++; $display("FAIL wrap_first got pc=%h instr=%h exp pc=800 instr=a0000000", if_pc, if_instr);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (if_pc !== 32'hFFFF_FFFC || if_instr !== 32'hA000_01FF) begin
            n_errors++; $display("FAIL wrap_top got pc=%h instr=%h exp pc=fffffffc instr=a00001ff", if_pc, if_instr);
        end
        tick();
        n_checks++;
        if (if_pc !== 32'h0 || if_instr !== 32'hA000_0000) begin
            n_errors++; $display("FAIL wrap_pc32 got pc=%h instr=%h exp pc=0 instr=a0000000", if_pc, if_instr);
        end
    endtask

    task automatic test_fetch_en;
        do_reset();
        rst = 1'b0;
        tick();
        fetch_en = 1'b0;
        tick();
        n_checks++;
        if (if_valid !== 1'b0 || fetch_count !== 32'd1) begin
            n_errors++; $display("FAIL fen_stop got v=%0b cnt=%0d exp v=0 cnt=1", if_valid, fetch_count);
        end
        tick();
        fetch_en = 1'b1;
        #1;
        n_checks++;
        if (if_valid !== 1'b0 || imem_address !== 9'd1) begin
            n_errors++; $display("FAIL fen_hold got v=%0b addr=%0d exp v=0 addr=1", if_valid, imem_address);
        end
        tick();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'd4 || if_instr !== 32'hA000_0001) begin
            n_errors++; $display("FAIL fen_resume got v=%0b pc=%h instr=%h exp v=1 pc=4 instr=a0000001", if_valid, if_pc, if_instr);
        end
        if_ready = 1'b0;
        fetch_en = 1'b0;
        tick();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'd4 || if_instr !== 32'hA000_0001) begin
            n_errors++; $display("FAIL fen_stall_held got v=%0b pc=%h instr=%h exp v=1 pc=4 instr=a0000001", if_valid, if_pc, if_instr);
        end
        if_ready = 1'b1;
        tick();
        n_checks++;
        if (if_valid !== 1'b0 || fetch_count !== 32'd2) begin
            n_errors++; $display("FAIL fen_stall_drain got v=%0b cnt=%0d exp v=0 cnt=2", if_valid, fetch_count);
        end
        fetch_en = 1'b1;
    endtask

    task automatic test_reset_midstream;
        do_reset();
        rst = 1'b0;
        tick(); tick(); tick();
        if_ready = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (if_valid !== 1'b0 || imem_address !== 9'd0) begin
            n_errors++; $display("FAIL rstmid_out got v=%0b addr=%0d exp v=0 addr=0", if_valid, imem_address);
        end
        tick();
        rst      = 1'b0;
        if_ready = 1'b1;
        #1;
        n_checks++;
        if (fetch_count !== 32'd0 || if_valid !== 1'b0 || imem_address !== 9'd0) begin
            n_errors++; $display("FAIL rstmid_state got cnt=%0d v=%0b addr=%0d exp cnt=0 v=0 addr=0", fetch_count, if_valid, imem_address);
        end
        tick();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'd0 || if_instr !== 32'hA000_0000) begin
            n_errors++; $display("FAIL rstmid_restart got v=%0b pc=%h instr=%h exp v=1 pc=0 instr=a0000000", if_valid, if_pc, if_instr);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = 32'hA000_0000 + i;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_misaligned();
        test_wrap();
        test_fetch_en();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
